pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that replaces the fixed-field, free-running inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined MIPS core. Each stage carries a control bundle and a data payload with a valid/ready handshake, an optional skid entry for full throughput under backpressure, and synchronous flush for branch and hazard squashing. A saturating stall counter supports performance analysis.

## Interface
Parameters:
- CTRL_W, 7: control bundle width; 7 covers regDst, aluSrc, memtoReg, regWrite, memWrite and aluOp[1:0].
- DATA_W, 106: payload width; 106 covers the two 5-bit register addresses plus immediate, rs and rt data.
- NOP_CTRL, {CTRL_W{1'b0}}: control value driven whenever the stage holds no valid entry.
- SKID, 1: 1 adds a one-entry skid buffer and makes in_ready registered; 0 omits it.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_ctrl  out  CTRL_W  registered control; equals NOP_CTRL whenever out_valid=0.
- out_data  out  DATA_W  registered payload.
- flush  in  1  synchronous squash of all entries held in the stage.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid && in_ready. Issue: out_valid && out_ready.
- State: output register (out_valid, out_ctrl, out_data) and, when SKID=1, a skid register (skid_valid, skid_ctrl, skid_data).
- Ready rule:
  - SKID=1: in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - SKID=0: in_ready = !out_valid || out_ready.
- Each edge, with flush=0:
  - If the output register is empty or issuing, it loads the skid entry when skid_valid=1 (skid empties, or refills with the current accept). Otherwise it loads the accepted input. Otherwise out_valid becomes 0.
  - If the output register is held (out_valid && !out_ready) and an input is accepted, the input goes to skid (SKID=1 only).
- Entries issue in the order they were accepted; no entry is duplicated or dropped.
- A bubble (out_valid=0) forces out_ctrl=NOP_CTRL, so write enables are inactive. out_data holds its last value and is don't-care.
- flush=1 at an edge:
  - out_valid←0, skid_valid←0, out_ctrl←NOP_CTRL.
  - Any accept in that cycle is discarded.
  - Flush has priority over every other update.
- stall_cnt:
  - cnt_clr=1 → 0 (priority over increment).
  - Otherwise it increments on each edge where out_valid && !out_ready, saturating at 2^CNT_W−1.
  - Flush does not clear it.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_ctrl=NOP_CTRL, out_data=0, skid_valid=0, in_ready=1, stall_cnt=0. Normal operation resumes on the first edge after rst_n rises.
- Reset mid-transfer: all entries are lost; no partial state survives.
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle).
- Throughput: one entry per cycle sustained when out_ready=1.
  - SKID=1 sustains one per cycle under arbitrary out_ready patterns once the skid is used.
  - SKID=0 loses no entries, but its in_ready depends combinationally on out_ready.
- Skid full (SKID=1): in_ready=0 in the cycle after the skid fills. It returns to 1 in the cycle after the output issues and the skid drains, provided no new entry is accepted into the skid in that same cycle.
- Simultaneous issue and accept with the skid empty: the output register reloads directly from the input, and the skid stays empty.
- Flush and out_ready=1 in the same cycle: the current output still counts as issued to downstream, and both registers are empty after the edge.

## Test plan
- Reset and pass-through:
  - Stimulus: hold rst_n=0 and check the reset values; then, with out_ready=1, stream 8 entries with in_data=k and in_ctrl=7'h5A.
  - Required response: out_data=k one cycle after each accept, in order; out_ctrl=NOP_CTRL in the gap cycles.
- Backpressure with SKID=1:
  - Stimulus: stream entries 1..6 while out_ready=0 for 3 cycles starting at cycle 2.
  - Required response: in_ready falls the cycle after the skid fills; entries 1..6 all issue in order; stall_cnt=3.
- Same stimulus with SKID=0:
  - Required response: in_ready=0 exactly in the cycles where out_valid=1 and out_ready=0; no entry is lost or repeated.
- Flush:
  - Stimulus: with both entries full, assert flush alongside in_valid=1 and in_data=99.
  - Required response: after the edge, out_valid=0, out_ctrl=NOP_CTRL and in_ready=1; entry 99 is never issued.
- Counter:
  - Stimulus: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles; then pulse cnt_clr together with a stall cycle.
  - Required response: stall_cnt saturates at 15, then reads 0 after the clear edge.
- Asynchronous reset mid-burst:
  - Stimulus: drop rst_n between clock edges while the skid is full.
  - Required response: outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional skid entry, synchronous flush
// and a saturating stall counter. Control reads NOP_CTRL whenever the stage is empty.
module pipe_stage_reg #(
    parameter int                CTRL_W   = 7,
    parameter int                DATA_W   = 106,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
    parameter bit                SKID     = 1'b1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic out_free;
    logic accept;

    // With the skid present, in_ready comes straight from the skid flop so
    // out_ready never reaches the upstream ready path.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = SKID ? !skid_valid_q : out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            out_ctrl_d   = NOP_CTRL;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (SKID && skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_ctrl_d   = skid_ctrl_q;
                out_data_d   = skid_data_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
                out_ctrl_d  = NOP_CTRL;
            end
        end else if (SKID && accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end

        if (!SKID) begin
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= NOP_CTRL;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= NOP_CTRL;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (4-bit counter) and a no-skid
// instance run side by side through pass-through, backpressure, flush, counter and reset.
module tb_pipe_stage_reg;

    localparam int CW = 7;
    localparam int DW = 106;

    logic clk;
    logic rst_n;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_cnt_clr;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [3:0]    a_stall_cnt;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_cnt_clr;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_ctrl   (a_in_ctrl),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_ctrl  (a_out_ctrl),
        .out_data  (a_out_data),
        .flush     (a_flush),
        .cnt_clr   (a_cnt_clr),
        .stall_cnt (a_stall_cnt)
    );

    pipe_stage_reg #(.SKID(1'b0)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_ctrl   (b_in_ctrl),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ctrl  (b_out_ctrl),
        .out_data  (b_out_data),
        .flush     (b_flush),
        .cnt_clr   (b_cnt_clr),
        .stall_cnt (b_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          k_a, k_b, pk_a, pk_b;
    logic        acc_a, acc_b, pacc_a, pacc_b;
    int          q_a[$];
    int          q_b[$];
    logic [11:0] vpat;
    logic [11:0] exp_ra;
    logic [11:0] exp_rb;
    logic        rdy;

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_cnt_clr = 0;
        a_in_ctrl = '0; a_in_data = '0;
        b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_cnt_clr = 0;
        b_in_ctrl = '0; b_in_data = '0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_ctrl",  a_out_ctrl, 0);
        check("rst_a_data",  a_out_data, 0);
        check("rst_a_ready", a_in_ready, 1);
        check("rst_a_cnt",   a_stall_cnt, 0);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_b_ready", b_in_ready, 1);
        check("rst_b_cnt",   b_stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // pass-through with gaps, out_ready=1
        vpat = 12'b1110_1101_1001;
        a_out_ready = 1; b_out_ready = 1;
        a_in_ctrl = 7'h5A; b_in_ctrl = 7'h5A;
        k_a = 0; k_b = 0; pacc_a = 0; pacc_b = 0; pk_a = 0; pk_b = 0;
        for (int i = 0; i < 13; i++) begin
            a_in_valid = (i < 12) ? vpat[i] : 1'b0;
            b_in_valid = a_in_valid;
            a_in_data  = DW'(k_a);
            b_in_data  = DW'(k_b);
            #1;
            check("pt_a_valid", a_out_valid, pacc_a);
            check("pt_b_valid", b_out_valid, pacc_b);
            if (pacc_a) begin
                check("pt_a_data", a_out_data, pk_a);
                check("pt_a_ctrl", a_out_ctrl, 7'h5A);
            end else begin
                check("pt_a_nop", a_out_ctrl, 0);
            end
            if (pacc_b) begin
                check("pt_b_data", b_out_data, pk_b);
            end else begin
                check("pt_b_nop", b_out_ctrl, 0);
            end
            acc_a = a_in_valid && a_in_ready;
            acc_b = b_in_valid && b_in_ready;
            pacc_a = acc_a; pk_a = k_a;
            pacc_b = acc_b; pk_b = k_b;
            tick();
            if (acc_a) k_a++;
            if (acc_b) k_b++;
        end
        check("pt_a_count", k_a, 8);
        check("pt_b_count", k_b, 8);

        // backpressure: out_ready low during cycles 2..4
        exp_ra = 12'b111111_000_111;
        exp_rb = 12'b1111111_000_11;
        k_a = 1; k_b = 1;
        for (int i = 0; i < 12; i++) begin
            rdy = !(i >= 2 && i <= 4);
            a_out_ready = rdy; b_out_ready = rdy;
            a_in_valid = (k_a <= 6); a_in_data = DW'(k_a);
            b_in_valid = (k_b <= 6); b_in_data = DW'(k_b);
            #1;
            check("bp_a_ready", a_in_ready, exp_ra[i]);
            check("bp_b_ready", b_in_ready, exp_rb[i]);
            check("bp_b_rule", b_in_ready, !(b_out_valid && !b_out_ready));
            if (a_out_valid && a_out_ready) q_a.push_back(int'(a_out_data[15:0]));
            if (b_out_valid && b_out_ready) q_b.push_back(int'(b_out_data[15:0]));
            acc_a = a_in_valid && a_in_ready;
            acc_b = b_in_valid && b_in_ready;
            tick();
            if (acc_a) k_a++;
            if (acc_b) k_b++;
        end
        check("bp_a_issued", q_a.size(), 6);
        check("bp_b_issued", q_b.size(), 6);
        for (int j = 0; j < 6; j++) begin
            check("bp_a_order", (j < q_a.size()) ? q_a[j] : -1, j + 1);
            check("bp_b_order", (j < q_b.size()) ? q_b[j] : -1, j + 1);
        end
        check("bp_a_cnt", a_stall_cnt, 3);
        check("bp_b_cnt", b_stall_cnt, 3);
        b_in_valid = 0;

        // flush with both entries full
        a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 7'h11;
        a_in_data = DW'(10); tick();
        a_in_data = DW'(11); tick();
        check("fl_full_ready", a_in_ready, 0);
        a_flush = 1; a_in_data = DW'(99); tick();
        check("fl_valid", a_out_valid, 0);
        check("fl_ctrl",  a_out_ctrl, 0);
        check("fl_ready", a_in_ready, 1);
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no99", a_out_valid, 0);
        end
        // accept in a flush cycle is discarded
        a_flush = 1; a_in_valid = 1; a_in_data = DW'(77); tick();
        a_flush = 0; a_in_valid = 0;
        check("fl_acc_drop", a_out_valid, 0);
        tick();
        check("fl_acc_drop2", a_out_valid, 0);
        // flush together with issue
        a_in_valid = 1; a_in_data = DW'(20); tick();
        check("fl_load20", a_out_data, 20);
        a_in_valid = 0; a_flush = 1; tick();
        a_flush = 0;
        check("fl_issue_empty", a_out_valid, 0);

        // counter saturation and clear
        a_out_ready = 0; a_in_valid = 1; a_in_data = DW'(5); a_cnt_clr = 1; tick();
        a_cnt_clr = 0; a_in_valid = 0;
        check("cnt_cleared", a_stall_cnt, 0);
        repeat (20) tick();
        check("cnt_sat", a_stall_cnt, 15);
        check("cnt_hold_valid", a_out_valid, 1);
        a_cnt_clr = 1; tick();
        a_cnt_clr = 0;
        check("cnt_clr", a_stall_cnt, 0);
        tick();
        check("cnt_after_clr", a_stall_cnt, 1);

        // asynchronous reset while skid is full
        a_in_valid = 1; a_in_data = DW'(6); tick();
        check("ar_skid_full", a_in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", a_out_valid, 0);
        check("ar_ctrl",  a_out_ctrl, 0);
        check("ar_data",  a_out_data, 0);
        check("ar_ready", a_in_ready, 1);
        check("ar_cnt",   a_stall_cnt, 0);
        a_in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_post_valid", a_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
